cnn_result_join: RTL and testbench
==================================

# cnn_result_join

Downstream stage of `crop_plus_gaussian`. It joins the five independent per-crop CNN output streams (`cnn_output_0..4`) into one packed result beat. It converts the predicted crop-local centre (channels 1 and 2) back to full-image coordinates using the crop origin `crop_Y1`/`crop_X1`, and it signals completion after `NUM_CROPS` results.

## Interface
- `PIXEL_BIT_WIDTH`, 16: width of each CNN output word; two's-complement fixed point.
- `FP_FRAC`, 0: number of fractional bits in the CNN output words.
- `IMG_ROW_BITWIDTH`, 10: width of the crop Y origin.
- `IMG_COL_BITWIDTH`, 10: width of the crop X origin.
- `NUM_CROPS`, 1: number of results per `ap_start` run.

Ports:
- `ap_clk` in 1: the single clock. All logic is on the rising edge.
- `ap_rst` in 1: reset; synchronous and active-high.
- `ap_start` in 1: one-cycle pulse that arms a run.
- `ap_done` out 1: one-cycle pulse after the `NUM_CROPS`-th result handshake.
- `ap_idle` out 1: high when no run is armed.
- `cnn_output_<i>_TDATA` in `PIXEL_BIT_WIDTH`, for i=0..4: CNN output channel i.
- `cnn_output_<i>_TVALID` in 1 / `cnn_output_<i>_TREADY` out 1: AXI-stream handshake for channel i.
- `crop_Y1_TDATA` in `IMG_ROW_BITWIDTH`: crop origin row. `crop_Y1_TVALID` in 1 / `crop_Y1_TREADY` out 1.
- `crop_X1_TDATA` in `IMG_COL_BITWIDTH`: crop origin column. `crop_X1_TVALID` in 1 / `crop_X1_TREADY` out 1.
- `result_TDATA` out `5*PIXEL_BIT_WIDTH`: packed result; channel 0 occupies the LSBs.
- `result_TVALID` out 1 / `result_TREADY` in 1: AXI-stream handshake for the result.

## Operation
- There are 7 one-entry holding registers: `hold_<i>` for channels 0..4, plus `hold_Y` and `hold_X`. Each has a full flag.
- An input's TREADY equals the inverse of its holding register's full flag, ANDed with `run_active`.
- Inputs are accepted in any order and any interleaving. A channel that is full stalls its producer.
- Join condition: all 7 full flags are set, AND (`result_TVALID` is 0 OR `result_TREADY` is 1).
- On the join:
  - The output register loads.
  - All full flags clear in the same cycle.
  - `result_TVALID` goes to 1.
- Channels 0, 3 and 4 pass through unchanged.
- Channel 1 is the x-centre: ch1 + (`crop_X1` << `FP_FRAC`).
- Channel 2 is the y-centre: ch2 + (`crop_Y1` << `FP_FRAC`).
- Offset arithmetic rules:
  - The addition is signed at `PIXEL_BIT_WIDTH`+1 bits, with the zero-extended offset.
  - The sum saturates to [-2^(W-1), 2^(W-1)-1].
- `result_TVALID` stays high and `result_TDATA` stays stable until the handshake.
- Run FSM states and transitions:
  - IDLE: `ap_idle`=1, all TREADYs are 0. On `ap_start`, clear the result counter and go to RUN.
  - RUN: on each result handshake, increment the counter. On the `NUM_CROPS`-th handshake, pulse `ap_done` for one cycle and return to IDLE.
- `ap_start` while in RUN is ignored.
- Holding registers that are still full when the FSM returns to IDLE are cleared.
- Reset values: FSM in IDLE, all full flags 0, `result_TVALID` 0, `result_TDATA` 0, `ap_done` 0, `ap_idle` 1, counter 0.
- Reset mid-operation discards all held and pending data, including an unaccepted result.

## Timing
- Latency: the last input handshake is at edge k; `result_TVALID`=1 after edge k+1.
- Throughput: at most one result every 2 cycles, because the holds clear at the join and TREADY rises the following cycle.
- TREADYs are registered-flag derived. There is no combinational path from any TVALID or `result_TREADY` to any input TREADY.
- Simultaneous output handshake and join in the same cycle: the new result replaces the old one with no bubble, and `result_TVALID` stays 1.
- `ap_done` is asserted in the cycle after the final result handshake edge.

## Configuration
- `CNN_RESULT_ROI_OFFSET_EN`
  - Defined: the crop-origin channels join as described and the offset/saturation adders are present.
  - Undefined:
    - Channels 1 and 2 pass through unchanged.
    - `crop_Y1_TREADY`/`crop_X1_TREADY` are 1 whenever the FSM is in RUN, and their data is discarded.
    - The join condition covers only the 5 CNN channels.

## Test plan
- Defaults, `CNN_RESULT_ROI_OFFSET_EN` defined. Start; ch0..4 = 7, 20, 30, 4, 5; Y1=10, X1=10; all valid together; `result_TREADY`=1 → one result {5, 4, 40, 30, 7} one cycle after the inputs; `ap_done` pulses; `ap_idle` returns to 1.
- Stagger the inputs: ch3 arrives 50 cycles after the others; `result_TREADY`=0 for a further 20 cycles → `result_TVALID` holds with stable data; all input TREADYs are 0 while their channels are full.
- Saturation: ch1=0x7FF0, X1=0x3FF → ch1 out = 0x7FFF; ch2=0x8000, Y1=0 → ch2 out = 0x8000.
- `NUM_CROPS`=3, random TVALID/TREADY on all channels → exactly 3 results in order; `ap_done` pulses once, after the third handshake; no data is lost or duplicated.
- `ap_rst` asserted while 3 channels are held and a result is pending → next cycle: `result_TVALID`=0, all full flags 0, `ap_idle`=1.
- Macro undefined, same stimulus as the first scenario → result {5, 4, 30, 20, 7}; crop TREADYs stay 1 throughout RUN.

Source files
------------

// File: rtl/cnn_result_join.sv
// cnn_result_join: joins five CNN output streams and the crop origin
// into one packed result, shifting the predicted centre to full-image
// coordinates; counts NUM_CROPS results per ap_start run.
// Ports: ap_clk/ap_rst (sync, active-high), ap_start/ap_done/ap_idle,
// cnn_output_0..4 and crop_Y1/crop_X1 AXI-stream inputs, result output.
// Macro CNN_RESULT_ROI_OFFSET_EN: join the crop origin and apply the
// saturating offset to channels 1/2; undefined passes them through.
module cnn_result_join #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int FP_FRAC          = 0,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int NUM_CROPS        = 1
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_idle,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_0_TDATA,
  input  logic                         cnn_output_0_TVALID,
  output logic                         cnn_output_0_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_1_TDATA,
  input  logic                         cnn_output_1_TVALID,
  output logic                         cnn_output_1_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_2_TDATA,
  input  logic                         cnn_output_2_TVALID,
  output logic                         cnn_output_2_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_3_TDATA,
  input  logic                         cnn_output_3_TVALID,
  output logic                         cnn_output_3_TREADY,
  input  logic [PIXEL_BIT_WIDTH-1:0]   cnn_output_4_TDATA,
  input  logic                         cnn_output_4_TVALID,
  output logic                         cnn_output_4_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0]  crop_Y1_TDATA,
  input  logic                         crop_Y1_TVALID,
  output logic                         crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0]  crop_X1_TDATA,
  input  logic                         crop_X1_TVALID,
  output logic                         crop_X1_TREADY,
  output logic [5*PIXEL_BIT_WIDTH-1:0] result_TDATA,
  output logic                         result_TVALID,
  input  logic                         result_TREADY
);

  localparam int W  = PIXEL_BIT_WIDTH;
  localparam int CW = $clog2(NUM_CROPS + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_done;
  logic [4:0]     r_full;
  logic [W-1:0]   r_hold [5];
  logic           r_valid;
  logic [5*W-1:0] r_data;

  logic [W-1:0]   w_din [5];
  logic [4:0]     w_vin;
  logic [4:0]     w_rdy;
  logic [4:0]     w_fire;
  logic           w_run;
  logic           w_all;
  logic           w_hs;
  logic           w_last;
  logic           w_join;
  logic           w_clr;
  logic [W-1:0]   w_ch1;
  logic [W-1:0]   w_ch2;
  logic [5*W-1:0] w_res;

  assign w_din[0] = cnn_output_0_TDATA;
  assign w_din[1] = cnn_output_1_TDATA;
  assign w_din[2] = cnn_output_2_TDATA;
  assign w_din[3] = cnn_output_3_TDATA;
  assign w_din[4] = cnn_output_4_TDATA;

  assign w_vin = {cnn_output_4_TVALID,
                  cnn_output_3_TVALID,
                  cnn_output_2_TVALID,
                  cnn_output_1_TVALID,
                  cnn_output_0_TVALID};

  assign w_run  = (r_state == S_RUN);
  assign w_rdy  = ~r_full & {5{w_run}};
  assign w_fire = w_vin & w_rdy;

  assign cnn_output_0_TREADY = w_rdy[0];
  assign cnn_output_1_TREADY = w_rdy[1];
  assign cnn_output_2_TREADY = w_rdy[2];
  assign cnn_output_3_TREADY = w_rdy[3];
  assign cnn_output_4_TREADY = w_rdy[4];

  assign w_hs   = r_valid & result_TREADY;
  assign w_last = w_hs & w_run &
                  (r_cnt == CW'(NUM_CROPS - 1));

`ifdef CNN_RESULT_ROI_OFFSET_EN
  logic                        r_full_y;
  logic                        r_full_x;
  logic [IMG_ROW_BITWIDTH-1:0] r_hold_y;
  logic [IMG_COL_BITWIDTH-1:0] r_hold_x;
  logic                        w_rdy_y;
  logic                        w_rdy_x;
  logic [W:0]                  w_offy;
  logic [W:0]                  w_offx;

  // Sign-extended word plus non-negative offset, clamped to W bits.
  function automatic logic [W-1:0] f_sat_add(
    input logic [W-1:0] a,
    input logic [W:0]   off
  );
    logic [W:0] s;
    s = {a[W-1], a} + off;
    if (s[W] != s[W-1])
      f_sat_add = s[W] ? {1'b1, {(W-1){1'b0}}}
                       : {1'b0, {(W-1){1'b1}}};
    else
      f_sat_add = s[W-1:0];
  endfunction

  assign w_rdy_y = ~r_full_y & w_run;
  assign w_rdy_x = ~r_full_x & w_run;
  assign crop_Y1_TREADY = w_rdy_y;
  assign crop_X1_TREADY = w_rdy_x;
  assign w_all = (&r_full) & r_full_y & r_full_x;

  assign w_offy = {{(W+1-IMG_ROW_BITWIDTH){1'b0}}, r_hold_y}
                  << FP_FRAC;
  assign w_offx = {{(W+1-IMG_COL_BITWIDTH){1'b0}}, r_hold_x}
                  << FP_FRAC;
  assign w_ch1 = f_sat_add(r_hold[1], w_offx);
  assign w_ch2 = f_sat_add(r_hold[2], w_offy);
`else
  logic w_unused;

  // Crop origin is drained and dropped while a run is active.
  assign crop_Y1_TREADY = w_run;
  assign crop_X1_TREADY = w_run;
  assign w_unused = ^{crop_Y1_TDATA, crop_Y1_TVALID,
                      crop_X1_TDATA, crop_X1_TVALID};
  assign w_all = &r_full;
  assign w_ch1 = r_hold[1];
  assign w_ch2 = r_hold[2];
`endif

  // The final handshake ends the run, so no further join is taken.
  assign w_join = w_all & (~r_valid | result_TREADY) & ~w_last;
  assign w_clr  = w_join | w_last;
  assign w_res  = {r_hold[4], r_hold[3], w_ch2, w_ch1, r_hold[0]};

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (w_fire[i]) r_hold[i] <= w_din[i];
    end
`ifdef CNN_RESULT_ROI_OFFSET_EN
    if (crop_Y1_TVALID && w_rdy_y) r_hold_y <= crop_Y1_TDATA;
    if (crop_X1_TVALID && w_rdy_x) r_hold_x <= crop_X1_TDATA;
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_full  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef CNN_RESULT_ROI_OFFSET_EN
      r_full_y <= 1'b0;
      r_full_x <= 1'b0;
`endif
    end else begin
      r_done <= w_last;

      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_hs)   r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      for (int i = 0; i < 5; i++) begin
        if (w_clr)          r_full[i] <= 1'b0;
        else if (w_fire[i]) r_full[i] <= 1'b1;
      end
`ifdef CNN_RESULT_ROI_OFFSET_EN
      if (w_clr)
        r_full_y <= 1'b0;
      else if (crop_Y1_TVALID && w_rdy_y)
        r_full_y <= 1'b1;
      if (w_clr)
        r_full_x <= 1'b0;
      else if (crop_X1_TVALID && w_rdy_x)
        r_full_x <= 1'b1;
`endif

      // A join in the same cycle as a handshake replaces the beat.
      if (w_join)    r_valid <= 1'b1;
      else if (w_hs) r_valid <= 1'b0;
      if (w_join)    r_data  <= w_res;
    end
  end

  assign ap_done       = r_done;
  assign ap_idle       = (r_state == S_IDLE);
  assign result_TVALID = r_valid;
  assign result_TDATA  = r_data;

endmodule

// File: tb/tb_cnn_result_join.sv
// tb_cnn_result_join: randomized per-channel traffic against an
// integer reference model of cnn_result_join (NUM_CROPS = 3).
module tb_cnn_result_join;

  localparam int NC   = 3;
  localparam int FRAC = 0;

`ifdef CNN_RESULT_ROI_OFFSET_EN
  localparam logic [79:0] EXP1 =
    {16'd5, 16'd4, 16'd40, 16'd30, 16'd7};
  localparam int  NJOIN    = 7;
  localparam logic CROP_RDY = 1'b0;
`else
  localparam logic [79:0] EXP1 =
    {16'd5, 16'd4, 16'd30, 16'd20, 16'd7};
  localparam int  NJOIN    = 5;
  localparam logic CROP_RDY = 1'b1;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic [15:0] tv_data [7];
  logic        tv_valid [7];
  logic        tready [7];
  logic [79:0] result_TDATA;
  logic        result_TVALID;
  logic        result_TREADY;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          vprob = 100;
  int          rprob = 100;
  bit          rdy_hold = 0;
  bit          drv_mute = 0;
  bit          mon_mute = 1;
  int          dly [7];
  int          hs_cyc [7][256];
  int          n_sent [7];
  int          mon_cnt = 0;
  int          n_done = 0;
  logic [15:0] in_q [7][$];
  logic [79:0] exp_q [$];

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  cnn_result_join #(
    .PIXEL_BIT_WIDTH (16),
    .FP_FRAC         (FRAC),
    .IMG_ROW_BITWIDTH(10),
    .IMG_COL_BITWIDTH(10),
    .NUM_CROPS       (NC)
  ) dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .ap_start           (ap_start),
    .ap_done            (ap_done),
    .ap_idle            (ap_idle),
    .cnn_output_0_TDATA (tv_data[0]),
    .cnn_output_0_TVALID(tv_valid[0]),
    .cnn_output_0_TREADY(tready[0]),
    .cnn_output_1_TDATA (tv_data[1]),
    .cnn_output_1_TVALID(tv_valid[1]),
    .cnn_output_1_TREADY(tready[1]),
    .cnn_output_2_TDATA (tv_data[2]),
    .cnn_output_2_TVALID(tv_valid[2]),
    .cnn_output_2_TREADY(tready[2]),
    .cnn_output_3_TDATA (tv_data[3]),
    .cnn_output_3_TVALID(tv_valid[3]),
    .cnn_output_3_TREADY(tready[3]),
    .cnn_output_4_TDATA (tv_data[4]),
    .cnn_output_4_TVALID(tv_valid[4]),
    .cnn_output_4_TREADY(tready[4]),
    .crop_Y1_TDATA      (tv_data[5][9:0]),
    .crop_Y1_TVALID     (tv_valid[5]),
    .crop_Y1_TREADY     (tready[5]),
    .crop_X1_TDATA      (tv_data[6][9:0]),
    .crop_X1_TVALID     (tv_valid[6]),
    .crop_X1_TREADY     (tready[6]),
    .result_TDATA       (result_TDATA),
    .result_TVALID      (result_TVALID),
    .result_TREADY      (result_TREADY)
  );

  task automatic chk(input string tag,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [79:0] model(
    input logic [15:0] c0, c1, c2, c3, c4, y, x);
    int r1, r2;
`ifdef CNN_RESULT_ROI_OFFSET_EN
    r1 = clamp16(s16(c1) + int'(x) * (1 << FRAC));
    r2 = clamp16(s16(c2) + int'(y) * (1 << FRAC));
`else
    r1 = s16(c1);
    r2 = s16(c2);
`endif
    return {c4, c3, r2[15:0], r1[15:0], c0};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(3))
      0:       return 16'h7FF0 | 16'($urandom_range(15));
      1:       return 16'h8000 | 16'($urandom_range(15));
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic push_set(input logic [15:0] c0, c1, c2,
                          c3, c4, y, x);
    logic [15:0] ym, xm;
    ym = y & 16'h03FF;
    xm = x & 16'h03FF;
    in_q[0].push_back(c0);
    in_q[1].push_back(c1);
    in_q[2].push_back(c2);
    in_q[3].push_back(c3);
    in_q[4].push_back(c4);
    in_q[5].push_back(ym);
    in_q[6].push_back(xm);
    exp_q.push_back(model(c0, c1, c2, c3, c4, ym, xm));
  endtask

  task automatic push_rand();
    push_set(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
             16'($urandom_range(1023)),
             16'($urandom_range(1023)));
  endtask

  task automatic start();
    @(negedge ap_clk);
    ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int d0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge ap_clk);
      if (ap_idle && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_finish"}, 80'(ok), 80'(1));
    repeat (3) @(negedge ap_clk);
    chk({tag, "_done_cnt"}, 80'(n_done - d0), 80'(1));
    chk({tag, "_idle"}, 80'(ap_idle), 80'(1));
  endtask

  for (genvar g = 0; g < 7; g++) begin : g_drv
    initial begin
      bit sent;
      sent = 1'b0;
      tv_valid[g] = 1'b0;
      tv_data[g]  = '0;
      forever begin
        @(negedge ap_clk);
        if (sent || drv_mute) begin
          tv_valid[g] = 1'b0;
          sent = 1'b0;
        end
        if (!drv_mute && !tv_valid[g] && in_q[g].size() > 0) begin
          if (dly[g] > 0) begin
            dly[g]--;
          end else if (int'($urandom_range(99)) < vprob) begin
            tv_valid[g] = 1'b1;
            tv_data[g]  = in_q[g][0];
          end
        end
        if (tv_valid[g] && tready[g]) begin
          if (n_sent[g] < 256) hs_cyc[g][n_sent[g]] = cyc + 1;
          n_sent[g]++;
          void'(in_q[g].pop_front());
          sent = 1'b1;
        end
      end
    end
  end

  initial begin
    bit          stall;
    bit          exp_done;
    logic [79:0] sd;
    stall = 1'b0;
    exp_done = 1'b0;
    sd = '0;
    result_TREADY = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (mon_mute) begin
        stall = 1'b0;
        exp_done = 1'b0;
        mon_cnt = 0;
        result_TREADY = 1'b0;
      end else begin
        if (ap_done) n_done++;
        if (ap_done || exp_done)
          chk("ap_done", 80'(ap_done), 80'(exp_done));
        exp_done = 1'b0;
        if (stall) begin
          chk("hold_valid", 80'(result_TVALID), 80'(1));
          chk("hold_data", result_TDATA, sd);
          stall = 1'b0;
        end
        result_TREADY = !rdy_hold &&
                        (int'($urandom_range(99)) < rprob);
        if (result_TVALID) begin
          if (result_TREADY) begin
            if (exp_q.size() == 0)
              chk("extra_result", result_TDATA, 80'(0));
            else
              chk("result", result_TDATA, exp_q.pop_front());
            mon_cnt++;
            if (mon_cnt == NC) begin
              mon_cnt = 0;
              exp_done = 1'b1;
            end
          end else begin
            stall = 1'b1;
            sd = result_TDATA;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0;
    int last;
    ap_rst = 1'b1;
    ap_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dly[i] = 0;
      n_sent[i] = 0;
    end
    repeat (3) @(negedge ap_clk);
    chk("rst_idle", 80'(ap_idle), 80'(1));
    chk("rst_valid", 80'(result_TVALID), 80'(0));
    chk("rst_data", result_TDATA, 80'(0));
    chk("rst_done", 80'(ap_done), 80'(0));
    chk("rst_rdy0", 80'(tready[0]), 80'(0));
    chk("rst_rdy_crop", 80'(tready[6]), 80'(0));
    ap_rst = 1'b0;
    mon_mute = 1'b0;

    push_set(16'd7, 16'd20, 16'd30, 16'd4, 16'd5,
             16'd10, 16'd10);
    push_set(16'h0001, 16'h7FF0, 16'h8000, 16'h0002,
             16'h0003, 16'h0000, 16'h03FF);
    push_rand();
    d0 = n_done;
    start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (result_TVALID) begin
        ok = 1'b1;
        break;
      end
    end
    chk("A_first_valid", 80'(ok), 80'(1));
    last = 0;
    for (int c = 0; c < NJOIN; c++)
      if (hs_cyc[c][0] > last) last = hs_cyc[c][0];
    chk("A_latency", 80'(cyc), 80'(last + 1));
    chk("A_first_data", result_TDATA, EXP1);
    wait_run("A", d0);

    rdy_hold = 1'b1;
    dly[3] = 50;
    repeat (3) push_rand();
    d0 = n_done;
    start();
    repeat (30) @(negedge ap_clk);
    chk("B_rdy0_full", 80'(tready[0]), 80'(0));
    chk("B_rdy1_full", 80'(tready[1]), 80'(0));
    chk("B_rdy3_wait", 80'(tready[3]), 80'(1));
    chk("B_rdy_crop", 80'(tready[6]), 80'(CROP_RDY));
    chk("B_no_valid", 80'(result_TVALID), 80'(0));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk);
      if (result_TVALID) begin
        ok = 1'b1;
        break;
      end
    end
    chk("B_valid", 80'(ok), 80'(1));
    repeat (20) @(negedge ap_clk);
    rdy_hold = 1'b0;
    wait_run("B", d0);

    vprob = 50;
    rprob = 50;
    repeat (3) push_rand();
    d0 = n_done;
    start();
    repeat (2) @(negedge ap_clk);
    start();
    wait_run("C", d0);

    vprob = 30;
    rprob = 80;
    repeat (3) push_rand();
    d0 = n_done;
    start();
    wait_run("C2", d0);

    vprob = 100;
    rprob = 100;
    rdy_hold = 1'b1;
    push_rand();
    in_q[0].push_back(rnd16());
    in_q[1].push_back(rnd16());
    in_q[2].push_back(rnd16());
    start();
    repeat (10) @(negedge ap_clk);
    chk("D_pending", 80'(result_TVALID), 80'(1));
    chk("D_held0", 80'(tready[0]), 80'(0));
    chk("D_free3", 80'(tready[3]), 80'(1));
    drv_mute = 1'b1;
    mon_mute = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("D_rst_valid", 80'(result_TVALID), 80'(0));
    chk("D_rst_idle", 80'(ap_idle), 80'(1));
    chk("D_rst_data", result_TDATA, 80'(0));
    for (int i = 0; i < 7; i++) in_q[i].delete();
    exp_q.delete();
    rdy_hold = 1'b0;
    start();
    chk("D_rdy0_clear", 80'(tready[0]), 80'(1));
    chk("D_rdy2_clear", 80'(tready[2]), 80'(1));
    d0 = n_done;
    drv_mute = 1'b0;
    mon_mute = 1'b0;
    repeat (3) push_rand();
    wait_run("D", d0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
